// File: rtl/mcu8_pkg.sv
// mcu8_pkg: shared opcodes, flag bit positions, execute-stage FSM encoding and default widths.
package mcu8_pkg;
  localparam int DATA_W_DEF = 8;
  localparam int ADDR_W_DEF = 4;
  localparam logic [3:0] OP_ADD = 4'h0;
  localparam logic [3:0] OP_ADC = 4'h1;
  localparam logic [3:0] OP_SUB = 4'h2;
  localparam logic [3:0] OP_SBC = 4'h3;
  localparam logic [3:0] OP_AND = 4'h4;
  localparam logic [3:0] OP_OR  = 4'h5;
  localparam logic [3:0] OP_XOR = 4'h6;
  localparam logic [3:0] OP_NOT = 4'h7;
  localparam logic [3:0] OP_SHL = 4'h8;
  localparam logic [3:0] OP_SHR = 4'h9;
  localparam logic [3:0] OP_MOV = 4'hA;
  localparam logic [3:0] OP_CMP = 4'hB;
  localparam logic [3:0] OP_MUL = 4'hC;
  localparam int FLG_Z = 3;
  localparam int FLG_C = 2;
  localparam int FLG_N = 1;
  localparam int FLG_V = 0;
  typedef enum logic [1:0] {ST_IDLE, ST_MUL, ST_WB_LO, ST_WB_HI} state_t;
endpackage

// File: rtl/alu_mul_seq.sv
// alu_mul_seq: unsigned shift-add multiplier, one partial product per enabled cycle.
module alu_mul_seq #(
  parameter int DATA_W = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  start,
  input  logic [DATA_W-1:0]     a,
  input  logic [DATA_W-1:0]     b,
  output logic                  busy,
  output logic                  done,
  output logic [2*DATA_W-1:0]   product
);
  localparam int CW = $clog2(DATA_W);
  logic [2*DATA_W-1:0] acc_a;
  logic [DATA_W-1:0] b_r;
  logic [CW-1:0] cnt;
  assign done = busy && cnt == CW'(DATA_W - 1);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_a   <= '0;
      b_r     <= '0;
      cnt     <= '0;
      busy    <= 1'b0;
      product <= '0;
    end else if (start) begin
      acc_a   <= {{DATA_W{1'b0}}, a};
      b_r     <= b;
      cnt     <= '0;
      busy    <= 1'b1;
      product <= '0;
    end else if (en && busy) begin
      product <= product + (b_r[0] ? acc_a : '0);
      acc_a   <= acc_a << 1;
      b_r     <= b_r >> 1;
      cnt     <= cnt + 1'b1;
      busy    <= !done;
    end
  end
endmodule

// File: rtl/alu_exec_stage.sv
// alu_exec_stage: execute stage between decoder and register file; single-cycle ALU,
// optional sequential 8x8 multiply on opcode C when ALU_MUL_EN is defined.
module alu_exec_stage
  import mcu8_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              EN,
  input  logic              In_Valid,
  output logic              In_Ready,
  input  logic [3:0]        Opcode,
  input  logic [ADDR_W-1:0] Dest_Addr,
  input  logic [DATA_W-1:0] Op_A,
  input  logic [DATA_W-1:0] Op_B,
  output logic              WR,
  output logic [ADDR_W-1:0] Write_Addr,
  output logic [DATA_W-1:0] Write_Data,
  output logic [3:0]        Flags,
  output logic              Busy
);
  localparam int M = DATA_W - 1;
  logic accept, cin, c_new, v_new, wr_op, fl_op, wr_r;
  logic [DATA_W:0] add_s, sub_s;
  logic [DATA_W-1:0] res;
  logic [3:0] flags_new;
  logic wb_wr, wb_fl;
  logic [ADDR_W-1:0] wb_addr;
  logic [DATA_W-1:0] wb_data;
  logic [3:0] wb_flags;
  assign accept = In_Valid && In_Ready;
  assign cin = Flags[FLG_C];
  // SUB/SBC carry is the borrow out of the 9-bit difference
  assign add_s = {1'b0, Op_A} + {1'b0, Op_B} + {{DATA_W{1'b0}}, Opcode == OP_ADC && cin};
  assign sub_s = {1'b0, Op_A} - {1'b0, Op_B} - {{DATA_W{1'b0}}, Opcode == OP_SBC && cin};
  always_comb begin
    res = Op_A;
    c_new = cin;
    v_new = 1'b0;
    wr_op = 1'b0;
    fl_op = 1'b0;
    case (Opcode)
      OP_ADD, OP_ADC: begin
        res = add_s[M:0];
        c_new = add_s[DATA_W];
        v_new = (Op_A[M] == Op_B[M]) && (add_s[M] != Op_A[M]);
        wr_op = 1'b1;
        fl_op = 1'b1;
      end
      OP_SUB, OP_SBC, OP_CMP: begin
        res = sub_s[M:0];
        c_new = sub_s[DATA_W];
        v_new = (Op_A[M] != Op_B[M]) && (sub_s[M] != Op_A[M]);
        wr_op = Opcode != OP_CMP;
        fl_op = 1'b1;
      end
      OP_AND, OP_OR, OP_XOR, OP_NOT, OP_MOV: begin
        res = Opcode == OP_AND ? Op_A & Op_B :
              Opcode == OP_OR  ? Op_A | Op_B :
              Opcode == OP_XOR ? Op_A ^ Op_B :
              Opcode == OP_NOT ? ~Op_A : Op_B;
        wr_op = 1'b1;
        fl_op = 1'b1;
      end
      OP_SHL, OP_SHR: begin
        res = Opcode == OP_SHL ? {Op_A[M-1:0], 1'b0} : {1'b0, Op_A[M:1]};
        c_new = Opcode == OP_SHL ? Op_A[M] : Op_A[0];
        wr_op = 1'b1;
        fl_op = 1'b1;
      end
      default: ;
    endcase
  end
  assign flags_new = {res == '0, c_new, res[M], v_new};
`ifdef ALU_MUL_EN
  state_t state, state_nx;
  logic mul_start, mul_busy, mul_done;
  logic [2*DATA_W-1:0] prod;
  logic [ADDR_W-1:0] dest_r;
  assign mul_start = accept && Opcode == OP_MUL;
  assign In_Ready = state == ST_IDLE && EN;
  assign Busy = state != ST_IDLE;
  always_comb begin
    state_nx = state == ST_IDLE  ? (mul_start ? ST_MUL : ST_IDLE) :
               state == ST_MUL   ? (mul_done || !mul_busy ? ST_WB_LO : ST_MUL) :
               state == ST_WB_LO ? ST_WB_HI : ST_IDLE;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      dest_r <= '0;
    end else if (EN) begin
      state <= state_nx;
      if (mul_start) dest_r <= Dest_Addr;
    end
  end
  alu_mul_seq #(.DATA_W(DATA_W)) u_mul (
    .clk(clk), .rst_n(rst_n), .en(EN), .start(mul_start), .a(Op_A), .b(Op_B),
    .busy(mul_busy), .done(mul_done), .product(prod)
  );
  // high byte goes to the next register, wrapping at the top of the file
  assign wb_wr = state == ST_WB_LO || state == ST_WB_HI;
  assign wb_fl = state == ST_WB_HI;
  assign wb_addr = wb_fl ? dest_r + 1'b1 : dest_r;
  assign wb_data = wb_fl ? prod[2*DATA_W-1:DATA_W] : prod[M:0];
  assign wb_flags = {prod == '0, |prod[2*DATA_W-1:DATA_W], prod[2*DATA_W-1], 1'b0};
`else
  assign In_Ready = EN;
  assign Busy = 1'b0;
  assign wb_wr = 1'b0;
  assign wb_fl = 1'b0;
  assign wb_addr = '0;
  assign wb_data = '0;
  assign wb_flags = '0;
`endif
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_r       <= 1'b0;
      Write_Addr <= '0;
      Write_Data <= '0;
      Flags      <= '0;
    end else if (EN) begin
      wr_r <= wb_wr || (accept && wr_op);
      if (wb_wr || (accept && wr_op)) begin
        Write_Addr <= wb_wr ? wb_addr : Dest_Addr;
        Write_Data <= wb_wr ? wb_data : res;
      end
      if (wb_fl || (accept && fl_op)) Flags <= wb_fl ? wb_flags : flags_new;
    end
  end
  // a pending write is held back while stalled and issued once EN returns
  assign WR = wr_r && EN;
endmodule

// File: tb/tb_alu_exec_stage.sv
// tb_alu_exec_stage: vector table plus hand sequences for stall, reset and multiply.
module tb_alu_exec_stage;
  typedef struct {
    logic [3:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [3:0] d;
    logic       wr;
    logic [7:0] data;
    logic [3:0] fl;
  } vec_t;
  typedef struct {
    logic [3:0] addr;
    logic [7:0] data;
  } wr_t;

  logic clk = 0, rst_n, EN, In_Valid, In_Ready, WR, Busy;
  logic [3:0] Opcode, Dest_Addr, Write_Addr, Flags;
  logic [7:0] Op_A, Op_B, Write_Data;
  int n_chk = 0, n_fail = 0;
  wr_t sb[$];
  vec_t vecs[$];

  alu_exec_stage dut (
    .clk(clk), .rst_n(rst_n), .EN(EN), .In_Valid(In_Valid), .In_Ready(In_Ready),
    .Opcode(Opcode), .Dest_Addr(Dest_Addr), .Op_A(Op_A), .Op_B(Op_B), .WR(WR),
    .Write_Addr(Write_Addr), .Write_Data(Write_Data), .Flags(Flags), .Busy(Busy)
  );

  always #5 clk = ~clk;

  // register-file view: sample the write port just before the capturing edge
  always @(negedge clk) begin
    #4;
    if (WR === 1'b1) begin
      n_chk++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_wr: got addr=%h data=%h, required no write", Write_Addr, Write_Data);
      end else begin
        wr_t e;
        e = sb.pop_front();
        if (Write_Addr !== e.addr || Write_Data !== e.data) begin
          n_fail++;
          $display("FAIL wr_port: got addr=%h data=%h, required addr=%h data=%h",
                   Write_Addr, Write_Data, e.addr, e.data);
        end
      end
    end
  end

  function automatic vec_t mk(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                              input logic [3:0] d, input logic wr, input logic [7:0] data,
                              input logic [3:0] fl);
    vec_t v;
    v.op = op; v.a = a; v.b = b; v.d = d; v.wr = wr; v.data = data; v.fl = fl;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                       input logic [3:0] d);
    In_Valid = 1; Opcode = op; Op_A = a; Op_B = b; Dest_Addr = d;
  endtask

  task automatic push(input logic [3:0] addr, input logic [7:0] data);
    wr_t e;
    e.addr = addr; e.data = data;
    sb.push_back(e);
  endtask

`ifdef ALU_MUL_EN
  task automatic run_mul(input int stall_at, output int low, output int last);
    @(negedge clk);
    drive(4'hC, 8'hC8, 8'h0A, 4'hF);
    push(4'hF, 8'hD0);
    push(4'h0, 8'h07);
    low = 0;
    last = -1;
    @(posedge clk);
    for (int k = 0; k <= 16; k++) begin
      if (k > 0) begin
        @(negedge clk);
        In_Valid = 0;
        EN = !(k >= stall_at && k < stall_at + 3);
        @(posedge clk);
      end
      #1;
      if (!In_Ready) low++;
      if (WR) last = k;
    end
    EN = 1;
  endtask
`endif

  initial begin
    vecs.push_back(mk(4'h0, 8'hFF, 8'h01, 4'h3, 1, 8'h00, 4'hC));
    vecs.push_back(mk(4'h1, 8'h10, 8'h20, 4'h1, 1, 8'h31, 4'h0));
    vecs.push_back(mk(4'h2, 8'h80, 8'h01, 4'h2, 1, 8'h7F, 4'h1));
    vecs.push_back(mk(4'hB, 8'h05, 8'h05, 4'h0, 0, 8'h00, 4'h8));
    vecs.push_back(mk(4'h2, 8'h01, 8'h02, 4'h4, 1, 8'hFF, 4'h6));
    vecs.push_back(mk(4'h3, 8'h10, 8'h01, 4'h5, 1, 8'h0E, 4'h0));
    vecs.push_back(mk(4'h8, 8'h81, 8'h00, 4'h6, 1, 8'h02, 4'h4));
    vecs.push_back(mk(4'h4, 8'hF0, 8'h3C, 4'h7, 1, 8'h30, 4'h4));
    vecs.push_back(mk(4'h5, 8'h0F, 8'h80, 4'h8, 1, 8'h8F, 4'h6));
    vecs.push_back(mk(4'h6, 8'hAA, 8'hAA, 4'h9, 1, 8'h00, 4'hC));
    vecs.push_back(mk(4'h9, 8'h01, 8'h00, 4'hA, 1, 8'h00, 4'hC));
    vecs.push_back(mk(4'h9, 8'h02, 8'h00, 4'hB, 1, 8'h01, 4'h0));
    vecs.push_back(mk(4'h7, 8'h0F, 8'h00, 4'hC, 1, 8'hF0, 4'h2));
    vecs.push_back(mk(4'hA, 8'h00, 8'h7E, 4'hD, 1, 8'h7E, 4'h0));
    vecs.push_back(mk(4'h0, 8'h7F, 8'h01, 4'hE, 1, 8'h80, 4'h3));
    vecs.push_back(mk(4'hD, 8'h00, 8'h00, 4'hF, 0, 8'h00, 4'h3));
    vecs.push_back(mk(4'hF, 8'h12, 8'h34, 4'hF, 0, 8'h00, 4'h3));
`ifndef ALU_MUL_EN
    vecs.push_back(mk(4'hC, 8'hC8, 8'h0A, 4'hF, 0, 8'h00, 4'h3));
`endif
    vecs.push_back(mk(4'h3, 8'h00, 8'h00, 4'h0, 1, 8'h00, 4'h8));
    vecs.push_back(mk(4'h2, 8'h00, 8'h01, 4'h2, 1, 8'hFF, 4'h6));
    vecs.push_back(mk(4'h1, 8'h7F, 8'h00, 4'h3, 1, 8'h80, 4'h3));

    rst_n = 1; EN = 1;
    drive(vecs[0].op, vecs[0].a, vecs[0].b, vecs[0].d);
    #1 rst_n = 0;
    repeat (3) begin
      @(posedge clk); #1;
      chk("rst_wr", WR, 0);
      chk("rst_flags", Flags, 0);
      chk("rst_busy", Busy, 0);
      chk("rst_addr", Write_Addr, 0);
      chk("rst_data", Write_Data, 0);
    end
    @(negedge clk);
    rst_n = 1;
    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].d);
      if (vecs[i].wr) push(vecs[i].d, vecs[i].data);
      @(posedge clk); #1;
      chk($sformatf("vec%0d_flags", i), Flags, vecs[i].fl);
      chk($sformatf("vec%0d_wr", i), WR, vecs[i].wr);
      chk($sformatf("vec%0d_ready", i), In_Ready, 1);
      @(negedge clk);
    end

    In_Valid = 0;
    @(negedge clk);
    drive(4'h0, 8'h01, 8'h01, 4'h2);
    push(4'h2, 8'h02);
    @(posedge clk);
    @(negedge clk);
    In_Valid = 0; EN = 0;
    repeat (3) begin
      @(posedge clk); #1;
      chk("stall_wr", WR, 0);
      chk("stall_ready", In_Ready, 0);
    end
    @(negedge clk);
    EN = 1;
    @(posedge clk); #1;
    chk("post_stall_flags", Flags, 4'h0);
    chk("post_stall_wr", WR, 0);

`ifdef ALU_MUL_EN
    begin
      int low, last;
      run_mul(100, low, last);
      chk("mul_ready_low", 16'(low), 10);
      chk("mul_last_wr", 16'(last), 10);
      chk("mul_flags", Flags, 4'h4);
      chk("mul_busy_end", Busy, 0);
      run_mul(4, low, last);
      chk("mul_stall_ready_low", 16'(low), 13);
      chk("mul_stall_last_wr", 16'(last), 13);
      chk("mul_stall_flags", Flags, 4'h4);
    end
    @(negedge clk);
    drive(4'hC, 8'hFF, 8'hFF, 4'h5);
    @(posedge clk);
    repeat (4) @(posedge clk);
    @(negedge clk);
    In_Valid = 0; rst_n = 0;
    #1;
    chk("mul_rst_busy", Busy, 0);
    chk("mul_rst_wr", WR, 0);
    @(negedge clk);
    rst_n = 1;
`endif

    @(negedge clk);
    drive(4'h0, 8'h80, 8'h80, 4'h6);
    @(posedge clk);
    @(negedge clk);
    In_Valid = 0; rst_n = 0;
    #1;
    chk("abort_wr", WR, 0);
    chk("abort_flags", Flags, 0);
    chk("abort_data", Write_Data, 0);
    @(negedge clk);
    rst_n = 1;
    drive(4'h0, 8'h80, 8'h80, 4'h1);
    push(4'h1, 8'h00);
    @(posedge clk); #1;
    chk("after_rst_flags", Flags, 4'hD);
    chk("after_rst_wr", WR, 1);
    @(negedge clk);
    In_Valid = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("sb_empty", 16'(sb.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
